// File: rtl/fpe_pkg.sv
// Shared widths and loader state encoding for the FPE feature path.
package fpe_pkg;
  localparam int FPE_VEC_W = 256;
  localparam int FPE_IN_W  = 32;
  localparam int FPE_CNT_W = 16;

  typedef enum logic [1:0] {
    LD_FILL = 2'd0,
    LD_FULL = 2'd1,
    LD_DROP = 2'd2
  } ld_state_e;

  // Counter width that stays legal when only one value is needed.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/feature_beat_packer.sv
// Assembly register for one feature vector: per-lane write enables driven by beat_cnt.
// Lanes are cleared whenever the vector is taken, so unfilled upper lanes read as zero.
module feature_beat_packer
  import fpe_pkg::*;
#(
  parameter int IN_W  = FPE_IN_W,
  parameter int VEC_W = FPE_VEC_W,
  parameter int BEATS = VEC_W / IN_W,
  parameter int BC_W  = cnt_bits(BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic             done,
  input  logic             take,
  input  logic [IN_W-1:0]  data,
  output logic [VEC_W-1:0] vec,
  output logic             last_beat
);
  logic [BC_W-1:0]                beat_cnt;
  logic [BEATS-1:0]               lane_we;
  logic [BEATS-1:0][IN_W-1:0]     vec_l;

  assign last_beat = (beat_cnt == BC_W'(BEATS - 1));
  assign vec       = vec_l;

  for (genvar j = 0; j < BEATS; j++) begin : g_lane
    logic [IN_W-1:0] lane_q;
    assign lane_we[j] = we & (beat_cnt == BC_W'(j));
    // Bypass the current beat so a completing vector can move out in the same edge.
    assign vec_l[j]   = lane_we[j] ? data : lane_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             lane_q <= '0;
      else if (clr | take)    lane_q <= '0;
      else if (lane_we[j])    lane_q <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           beat_cnt <= '0;
    else if (clr | done)  beat_cnt <= '0;
    else if (we)          beat_cnt <= beat_cnt + 1'b1;
  end
endmodule

// File: rtl/feature_vector_loader.sv
// Packs IN_W beats into VEC_W feature vectors and strobes them into regfile reg0.
// One assembling vector plus one pending vector keep the input streaming while the FPE is busy.
module feature_vector_loader
  import fpe_pkg::*;
#(
  parameter int IN_W  = FPE_IN_W,
  parameter int VEC_W = FPE_VEC_W,
  parameter int CNT_W = FPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             fpe_ready,
  output logic [VEC_W-1:0] wrf0_data,
  output logic             wrf0_data_v,
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] feat_cnt
);
  localparam int BEATS = VEC_W / IN_W;
  localparam bit MULTI = (BEATS > 1);

  ld_state_e        state, nxt;
  logic             held, held_n;
  logic             pend_v;
  logic [VEC_W-1:0] pend_q, vec;
  logic             acc, issue, slot_free, last_beat;
  logic             we, done, take, load, es_n, el_n;

  assign s_ready   = (state == LD_FILL) | (state == LD_DROP);
  assign acc       = s_valid & s_ready;
  assign issue     = pend_v & fpe_ready & ~wrf0_data_v & ~flush;
  assign slot_free = ~pend_v | issue;

  feature_beat_packer #(.IN_W(IN_W), .VEC_W(VEC_W), .BEATS(BEATS)) u_pack (
    .clk, .rst_n,
    .clr(flush), .we, .done, .take,
    .data(s_data), .vec, .last_beat
  );

  always_comb begin
    nxt    = state;
    held_n = held;
    we     = 1'b0;
    done   = 1'b0;
    take   = 1'b0;
    load   = 1'b0;
    es_n   = 1'b0;
    el_n   = 1'b0;
    case (state)
      LD_FILL: begin
        we = acc;
        if (acc & (s_last | last_beat)) begin
          done = 1'b1;
          es_n = s_last & ~last_beat;
          el_n = MULTI & last_beat & ~s_last;
          if (slot_free) begin
            take   = 1'b1;
            load   = 1'b1;
            held_n = 1'b0;
          end else begin
            held_n = 1'b1;
          end
          if (el_n)           nxt = LD_DROP;
          else if (!slot_free) nxt = LD_FULL;
        end
      end
      LD_FULL: begin
        if (slot_free) begin
          take   = 1'b1;
          load   = 1'b1;
          held_n = 1'b0;
          nxt    = LD_FILL;
        end
      end
      LD_DROP: begin
        // Overlong tail is discarded; a held vector may still drain to pend meanwhile.
        if (held & slot_free) begin
          take   = 1'b1;
          load   = 1'b1;
          held_n = 1'b0;
        end
        if (acc & s_last) nxt = held_n ? LD_FULL : LD_FILL;
      end
      default: nxt = LD_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LD_FILL;
      held  <= 1'b0;
    end else if (flush) begin
      state <= LD_FILL;
      held  <= 1'b0;
    end else begin
      state <= nxt;
      held  <= held_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_q    <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      feat_cnt  <= '0;
    end else if (flush) begin
      pend_v    <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      feat_cnt  <= '0;
    end else begin
      if (load)       pend_q <= vec;
      if (load)       pend_v <= 1'b1;
      else if (issue) pend_v <= 1'b0;
      err_short <= es_n;
      err_long  <= el_n;
      if (issue) feat_cnt <= feat_cnt + 1'b1;
    end
  end

  // Output register survives flush so an in-flight strobe completes with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrf0_data   <= '0;
      wrf0_data_v <= 1'b0;
    end else begin
      if (issue) wrf0_data <= pend_q;
      wrf0_data_v <= issue;
    end
  end
endmodule

// File: tb/tb_feature_vector_loader.sv
// Scoreboard bench: stimulus pushes expected vectors, a monitor pops on each reg0 strobe.
module tb_feature_vector_loader;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic         fpe_ready = 1'b0;
  logic [255:0] wrf0_data;
  logic         wrf0_data_v;
  logic         err_short, err_long;
  logic [15:0]  feat_cnt;

  typedef struct packed { logic [255:0] data; logic [15:0] cnt; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int n_es = 0, n_el = 0, n_strobe = 0;
  logic         prev_v = 1'b0;
  logic [255:0] last_data = '0;
  logic [15:0]  exp_cnt = '0;

  feature_vector_loader dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .fpe_ready(fpe_ready), .wrf0_data(wrf0_data), .wrf0_data_v(wrf0_data_v),
    .err_short(err_short), .err_long(err_long), .feat_cnt(feat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_short) n_es++;
      if (err_long)  n_el++;
      if (wrf0_data_v) begin
        exp_t e;
        n_strobe++;
        last_data = wrf0_data;
        chk("strobe_gap", {255'd0, prev_v}, 256'd0);
        if (exp_q.size() == 0) chk("unexpected_strobe", 256'd1, 256'd0);
        else begin
          e = exp_q.pop_front();
          chk("wrf0_data", wrf0_data, e.data);
          chk("feat_cnt_at_strobe", {240'd0, feat_cnt}, {240'd0, e.cnt});
        end
      end
      prev_v = wrf0_data_v;
    end else prev_v = 1'b0;
  end

  function automatic logic [255:0] model_vec(input logic [31:0] base, input logic [31:0] step,
                                             input int n);
    logic [255:0] v = '0;
    for (int i = 0; i < n && i < 8; i++) v[i*32 +: 32] = base + step * i;
    return v;
  endfunction

  task automatic push_exp(input logic [255:0] v);
    exp_t e;
    exp_cnt = exp_cnt + 1'b1;
    e.data = v;
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Caller sits just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int w = 0;
    s_data = d; s_valid = 1'b1; s_last = l;
    @(negedge clk);
    while (!s_ready && w < 500) begin @(negedge clk); w++; end
    if (!s_ready) chk("s_ready_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_seq(input logic [31:0] base, input logic [31:0] step,
                          input int n, input int last_idx);
    for (int i = 0; i < n; i++) send_beat(base + step * i, (i == last_idx));
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin @(posedge clk); w++; end
    chk("drain_timeout", {224'd0, 32'(exp_q.size())}, 256'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    int es0, el0, st0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_s_ready", {255'd0, s_ready}, 256'd1);
    chk("rst_wrf0_v", {255'd0, wrf0_data_v}, 256'd0);
    chk("rst_wrf0_data", wrf0_data, 256'd0);
    chk("rst_feat_cnt", {240'd0, feat_cnt}, 256'd0);
    fpe_ready = 1'b1;

    // 1: 0x11111111*k, k=0..7
    push_exp(model_vec(32'h0, 32'h11111111, 8));
    send_seq(32'h0, 32'h11111111, 8, 7);
    drain();
    chk("t1_lo", {224'd0, last_data[31:0]}, 256'd0);
    chk("t1_hi", {224'd0, last_data[255:224]}, {224'd0, 32'h77777777});
    chk("t1_feat_cnt", {240'd0, feat_cnt}, 256'd1);

    // 2: short frame A,B,C
    es0 = n_es;
    push_exp({160'h0, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
    send_seq(32'hA0A0A0A0, 32'h01010101, 3, 2);
    drain();
    chk("t2_err_short", 256'(n_es - es0), 256'd1);

    // 3: 10-beat frame, tail dropped, then an intact frame
    el0 = n_el; es0 = n_es;
    push_exp(model_vec(32'hB0000000, 32'h1, 8));
    send_seq(32'hB0000000, 32'h1, 10, 9);
    push_exp(model_vec(32'hC0C00000, 32'h10, 8));
    send_seq(32'hC0C00000, 32'h10, 8, 7);
    drain();
    chk("t3_err_long", 256'(n_el - el0), 256'd1);
    chk("t3_no_err_short", 256'(n_es - es0), 256'd0);

    // 4: back-pressure over three frames
    do_flush();
    fpe_ready = 1'b0;
    st0 = n_strobe;
    push_exp(model_vec(32'hD1000000, 32'h1, 8));
    send_seq(32'hD1000000, 32'h1, 8, 7);
    push_exp(model_vec(32'hD2000000, 32'h1, 8));
    send_seq(32'hD2000000, 32'h1, 8, 7);
    @(negedge clk);
    chk("t4_s_ready_full", {255'd0, s_ready}, 256'd0);
    chk("t4_no_strobe", 256'(n_strobe - st0), 256'd0);
    @(posedge clk); #1;
    push_exp(model_vec(32'hD3000000, 32'h1, 8));
    fork
      send_seq(32'hD3000000, 32'h1, 8, 7);
      begin repeat (6) @(posedge clk); #1; fpe_ready = 1'b1; end
    join
    drain();
    chk("t4_feat_cnt", {240'd0, feat_cnt}, 256'd3);

    // 5: flush on beat 4 of frame 2 while frame 1 is pending
    fpe_ready = 1'b0;
    send_seq(32'hE1000000, 32'h1, 8, 7);
    send_seq(32'hE2000000, 32'h1, 4, 99);
    s_data = 32'hE2000004; s_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; flush = 1'b0;
    exp_cnt = '0;
    st0 = n_strobe;
    fpe_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t5_no_strobe", 256'(n_strobe - st0), 256'd0);
    chk("t5_feat_cnt", {240'd0, feat_cnt}, 256'd0);
    push_exp(model_vec(32'hF0000000, 32'h01000001, 8));
    send_seq(32'hF0000000, 32'h01000001, 8, 7);
    drain();
    chk("t5_feat_cnt_after", {240'd0, feat_cnt}, 256'd1);

    // 6: async reset mid-frame
    send_seq(32'h99990000, 32'h1, 3, 99);
    s_data = 32'h99990003; s_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_wrf0_data", wrf0_data, 256'd0);
    chk("t6_wrf0_v", {255'd0, wrf0_data_v}, 256'd0);
    chk("t6_feat_cnt", {240'd0, feat_cnt}, 256'd0);
    chk("t6_errs", {254'd0, err_short, err_long}, 256'd0);
    s_valid = 1'b0;
    exp_cnt = '0;
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_s_ready", {255'd0, s_ready}, 256'd1);
    push_exp(model_vec(32'h12340000, 32'h11, 8));
    send_seq(32'h12340000, 32'h11, 8, 7);
    drain();
    chk("t6_feat_cnt_after", {240'd0, feat_cnt}, 256'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
